// File: rtl/branch_resolve_unit.sv
// Registered RV32I branch/jump resolution with a 2-bit-counter BHT and wrap-around perf counters.
// Define BRU_C_EXT_EN for 16-bit instruction support (2-byte alignment, compressed fall-through).
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              lookup_taken,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic [XLEN-1:0]   target_addr,
  input  logic [2:0]        branch_type,
  input  logic              branch,
  input  logic              jump,
  input  logic              pred_taken,
  input  logic              is_compressed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              branch_taken,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              misaligned_exception,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

`ifdef BRU_C_EXT_EN
  localparam int ALIGN = 1;
`else
  localparam int ALIGN = 2;
`endif
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic             cond;
  logic             br_eff;
  logic             valid_c;
  logic             aligned_c;
  logic             taken_c;
  logic             exc_c;
  logic             misp_c;
  logic [XLEN-1:0]  fallthrough;
  logic [IDX_W-1:0] in_idx;
  logic [IDX_W-1:0] lookup_idx;
  logic             accept;
  logic             fire;
  logic             train;

  logic             out_valid_reg;
  logic             taken_reg;
  logic             misp_reg;
  logic             exc_reg;
  logic [XLEN-1:0]  redirect_reg;
  logic             cond_reg;
  logic             br_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] branch_count_reg;
  logic [CNT_W-1:0] mispredict_count_reg;
  logic [1:0]       bht_reg [BHT_ENTRIES];
  logic [1:0]       bht_cur;
  logic [1:0]       bht_next;
  logic             unused_bits;

  always_comb begin
    cond = 1'b0;
    case (branch_type)
      3'b000:  cond = (src_a == src_b);
      3'b001:  cond = (src_a != src_b);
      3'b100:  cond = ($signed(src_a) <  $signed(src_b));
      3'b101:  cond = ($signed(src_a) >= $signed(src_b));
      3'b110:  cond = (src_a <  src_b);
      3'b111:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  // A jump wins when both branch and jump are asserted.
  assign br_eff    = branch & ~jump;
  assign valid_c   = (cond & br_eff) | jump;
  assign aligned_c = (target_addr[ALIGN-1:0] == '0);
  assign taken_c   = valid_c & aligned_c;
  assign exc_c     = valid_c & ~aligned_c;
  assign misp_c    = ~exc_c & ((taken_c != pred_taken) | (jump & ~pred_taken));

`ifdef BRU_C_EXT_EN
  assign fallthrough = in_pc + (is_compressed ? XLEN'(2) : XLEN'(4));
  assign unused_bits = ^lookup_pc;
`else
  assign fallthrough = in_pc + XLEN'(4);
  assign unused_bits = ^{lookup_pc, is_compressed};
`endif

  assign in_idx     = in_pc[IDX_W+ALIGN-1:ALIGN];
  assign lookup_idx = lookup_pc[IDX_W+ALIGN-1:ALIGN];

  assign in_ready = ~out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid_reg & out_ready & ~flush;
  assign train    = fire & br_reg & ~exc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      taken_reg     <= 1'b0;
      misp_reg      <= 1'b0;
      exc_reg       <= 1'b0;
      redirect_reg  <= '0;
      cond_reg      <= 1'b0;
      br_reg        <= 1'b0;
      idx_reg       <= '0;
    end else begin
      if (flush)            out_valid_reg <= 1'b0;
      else if (accept)      out_valid_reg <= 1'b1;
      else if (out_ready)   out_valid_reg <= 1'b0;
      // Data only moves on an accepted, unflushed request, so a stalled result stays stable.
      if (accept && !flush) begin
        taken_reg    <= taken_c;
        misp_reg     <= misp_c;
        exc_reg      <= exc_c;
        redirect_reg <= taken_c ? target_addr : fallthrough;
        cond_reg     <= cond;
        br_reg       <= br_eff;
        idx_reg      <= in_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else if (fire) begin
      branch_count_reg     <= branch_count_reg + CNT_W'(br_reg);
      mispredict_count_reg <= mispredict_count_reg + CNT_W'(misp_reg);
    end
  end

  assign bht_cur  = bht_reg[idx_reg];
  assign bht_next = cond_reg ? ((bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'b01)
                             : ((bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_reg[i] <= 2'b01;
    end else if (train) begin
      bht_reg[idx_reg] <= bht_next;
    end
  end

  // Reads the registered counter, so a same-cycle update is seen only next cycle.
  assign lookup_taken         = bht_reg[lookup_idx][1];
  assign out_valid            = out_valid_reg;
  assign branch_taken         = taken_reg;
  assign mispredict           = misp_reg;
  assign misaligned_exception = exc_reg;
  assign redirect_pc          = redirect_reg;
  assign branch_count         = branch_count_reg;
  assign mispredict_count     = mispredict_count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the resolve rules.
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  localparam int NENT = 64;
  localparam int CNTW = 32;
`ifdef BRU_C_EXT_EN
  localparam int ABYTES = 2;
  localparam bit CEXT   = 1'b1;
`else
  localparam int ABYTES = 4;
  localparam bit CEXT   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic lookup_taken;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_pc = '0, src_a = '0, src_b = '0, target_addr = '0;
  logic [2:0] branch_type = '0;
  logic branch = 1'b0, jump = 1'b0, pred_taken = 1'b0, is_compressed = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic branch_taken, mispredict, misaligned_exception;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(NENT), .CNT_W(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .src_a(src_a), .src_b(src_b), .target_addr(target_addr),
    .branch_type(branch_type), .branch(branch), .jump(jump),
    .pred_taken(pred_taken), .is_compressed(is_compressed),
    .out_valid(out_valid), .out_ready(out_ready),
    .branch_taken(branch_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .misaligned_exception(misaligned_exception),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int  m_bht [NENT];
  bit  e_valid, e_taken, e_misp, e_exc, e_cond, e_isbr;
  int  e_idx;
  logic [31:0] e_rpc;
  logic [31:0] m_bcnt, m_mcnt;

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / ABYTES) % NENT);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) m_bht[i] = 1;
      e_valid = 0; e_taken = 0; e_misp = 0; e_exc = 0; e_cond = 0; e_isbr = 0;
      e_idx = 0; e_rpc = '0; m_bcnt = '0; m_mcnt = '0;
    end else begin
      bit fire, acc, c, isbr, v, al, tk, ex;
      logic [31:0] ft;
      fire = e_valid && out_ready && !flush;
      acc  = in_valid && (!e_valid || out_ready);
      if (fire) begin
        if (e_isbr) m_bcnt = m_bcnt + 1;
        if (e_misp) m_mcnt = m_mcnt + 1;
        if (e_isbr && !e_exc) begin
          if (e_cond && m_bht[e_idx] < 3) m_bht[e_idx] = m_bht[e_idx] + 1;
          if (!e_cond && m_bht[e_idx] > 0) m_bht[e_idx] = m_bht[e_idx] - 1;
        end
      end
      if (flush) e_valid = 0;
      else if (acc) begin
        case (branch_type)
          3'd0: c = (src_a == src_b);
          3'd1: c = (src_a != src_b);
          3'd4: c = ($signed(src_a) <  $signed(src_b));
          3'd5: c = ($signed(src_a) >= $signed(src_b));
          3'd6: c = (src_a <  src_b);
          3'd7: c = (src_a >= src_b);
          default: c = 0;
        endcase
        isbr = branch && !jump;
        v    = (c && isbr) || jump;
        al   = (target_addr % ABYTES) == 0;
        tk   = v && al;
        ex   = v && !al;
        ft   = in_pc + ((CEXT && is_compressed) ? 32'd2 : 32'd4);
        e_valid = 1; e_taken = tk; e_exc = ex; e_cond = c; e_isbr = isbr;
        e_misp  = !ex && ((tk != pred_taken) || (jump && !pred_taken));
        e_rpc   = tk ? target_addr : ft;
        e_idx   = m_index(in_pc);
      end else if (out_ready) e_valid = 0;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("branch_count", 64'(branch_count), 64'(m_bcnt));
    chk("mispredict_count", 64'(mispredict_count), 64'(m_mcnt));
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(!e_valid || out_ready));
      chk("lookup_taken", 64'(lookup_taken), 64'(m_bht[m_index(lookup_pc)] >= 2));
      if (e_valid) begin
        chk("branch_taken", 64'(branch_taken), 64'(e_taken));
        chk("mispredict", 64'(mispredict), 64'(e_misp));
        chk("misaligned", 64'(misaligned_exception), 64'(e_exc));
        chk("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst branch_count", 64'(branch_count), 64'd0);
  endtask

  task automatic req(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] tgt, input logic [2:0] ty, input bit br,
                     input bit jp, input bit pred);
    in_pc = pc; src_a = a; src_b = b; target_addr = tgt; branch_type = ty;
    branch = br; jump = jp; pred_taken = pred; is_compressed = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    do_reset();

    // 1: BEQ taken, predicted not-taken
    req(32'h100, 32'h5, 32'h5, 32'h140, 3'b000, 1, 0, 0);
    chk("t1 out_valid", 64'(out_valid), 64'd1);
    chk("t1 taken", 64'(branch_taken), 64'd1);
    chk("t1 mispredict", 64'(mispredict), 64'd1);
    chk("t1 redirect", 64'(redirect_pc), 64'h140);
    @(posedge clk); #1;
    chk("t1 mispredict_count", 64'(mispredict_count), 64'd1);
    chk("t1 branch_count", 64'(branch_count), 64'd1);

    // 2: signed vs unsigned less-than
    req(32'h180, 32'hFFFF_FFFF, 32'h1, 32'h1C0, 3'b100, 1, 0, 0);
    chk("t2 blt taken", 64'(branch_taken), 64'd1);
    req(32'h180, 32'hFFFF_FFFF, 32'h1, 32'h1C0, 3'b110, 1, 0, 0);
    chk("t2 bltu taken", 64'(branch_taken), 64'd0);
    chk("t2 bltu redirect", 64'(redirect_pc), 64'h184);

    // 3: jump to a halfword target
    do_reset();
    lookup_pc = 32'h100;
    req(32'h100, 32'h0, 32'h0, 32'h102, 3'b000, 0, 1, 0);
    chk("t3 taken", 64'(branch_taken), CEXT ? 64'd1 : 64'd0);
    chk("t3 misaligned", 64'(misaligned_exception), CEXT ? 64'd0 : 64'd1);
    chk("t3 mispredict", 64'(mispredict), CEXT ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    chk("t3 bht unchanged", 64'(lookup_taken), 64'd0);

    // 4: BHT saturation at pc 0x200
    do_reset();
    lookup_pc = 32'h200;
    for (int k = 0; k < 4; k++) begin
      req(32'h200, 32'h7, 32'h7, 32'h240, 3'b000, 1, 0, 1);
      @(posedge clk); #1;
      chk("t4 taken->1", 64'(lookup_taken), 64'd1);
    end
    req(32'h200, 32'h7, 32'h8, 32'h240, 3'b000, 1, 0, 1);
    @(posedge clk); #1;
    chk("t4 1 not-taken", 64'(lookup_taken), 64'd1);
    req(32'h200, 32'h7, 32'h8, 32'h240, 3'b000, 1, 0, 1);
    @(posedge clk); #1;
    chk("t4 2 not-taken", 64'(lookup_taken), 64'd0);

    // 5: backpressure then flush
    do_reset();
    lookup_pc = 32'h300;
    out_ready = 0;
    req(32'h300, 32'h1, 32'h1, 32'h380, 3'b000, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t5 held valid", 64'(out_valid), 64'd1);
      chk("t5 held redirect", 64'(redirect_pc), 64'h380);
      chk("t5 in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1; flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("t5 flushed valid", 64'(out_valid), 64'd0);
    chk("t5 branch_count", 64'(branch_count), 64'd0);
    chk("t5 bht", 64'(lookup_taken), 64'd0);
    flush = 1;
    req(32'h300, 32'h1, 32'h1, 32'h380, 3'b000, 1, 0, 0);
    flush = 0;
    chk("t5 discarded", 64'(out_valid), 64'd0);

    // 6: async reset during a stall
    do_reset();
    lookup_pc = 32'h400;
    for (int k = 0; k < 2; k++) begin
      req(32'h400, 32'h2, 32'h2, 32'h440, 3'b000, 1, 0, 0);
      @(posedge clk); #1;
    end
    chk("t6 trained", 64'(lookup_taken), 64'd1);
    out_ready = 0;
    req(32'h400, 32'h2, 32'h2, 32'h440, 3'b000, 1, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("t6 out_valid", 64'(out_valid), 64'd0);
    chk("t6 branch_count", 64'(branch_count), 64'd0);
    chk("t6 mispredict_count", 64'(mispredict_count), 64'd0);
    for (int k = 0; k < 8; k++) begin
      lookup_pc = 32'h400 + 32'(k * 4);
      #1 chk("t6 lookup", 64'(lookup_taken), 64'd0);
    end
    @(posedge clk); #1 rst_n = 1; out_ready = 1;

    // Randomized traffic, checked each cycle by the compare process
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [31:0] ops [5];
      ops[0] = 32'h0; ops[1] = 32'h1; ops[2] = 32'h5; ops[3] = 32'hFFFF_FFFF; ops[4] = 32'h8000_0000;
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      in_pc         = 32'h1000 + 32'($urandom_range(0, 31) * ABYTES);
      lookup_pc     = 32'h1000 + 32'($urandom_range(0, 31) * ABYTES);
      src_a         = ops[$urandom_range(0, 4)];
      src_b         = ops[$urandom_range(0, 4)];
      target_addr   = 32'h2000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) target_addr[1:0] = 2'b00;
      branch_type   = 3'($urandom_range(0, 7));
      branch        = ($urandom_range(0, 3) != 0);
      jump          = ($urandom_range(0, 3) == 0);
      pred_taken    = 1'($urandom_range(0, 1));
      is_compressed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised, registered branch resolution stage for the execute pipeline.
- Evaluates RV32I conditional branches and jumps on XLEN-wide operands.
- Checks target alignment and compares the outcome against a fetch-side prediction from an internal 2-bit BHT.
- Emits a one-cycle-latency resolve result with mispredict/redirect, trains the BHT, and keeps wrap-around perf counters.

Parameters:
XLEN, 32, operand/PC width
BHT_ENTRIES, 64, number of 2-bit counters (power of 2, >=2)
CNT_W, 32, perf counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of registered result
lookup_pc  input  XLEN  fetch PC for prediction
lookup_taken  output  1  combinational BHT prediction (counter MSB)
in_valid  input  1  resolve request
in_ready  output  1  = !out_valid | out_ready
in_pc  input  XLEN  PC of branch/jump
src_a, src_b  input  XLEN  compare operands
target_addr  input  XLEN  computed target (external adder)
branch_type  input  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU, others never taken
branch  input  1  conditional branch
jump  input  1  JAL/JALR (unconditional)
pred_taken  input  1  prediction fetch used for this instruction
is_compressed  input  1  16-bit instruction (used only with BRU_C_EXT_EN)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts
branch_taken  output  1  taken and aligned
mispredict  output  1  fetch must redirect
redirect_pc  output  XLEN  correct next PC
misaligned_exception  output  1  taken/jump to misaligned target
branch_count  output  CNT_W  resolved conditional branches
mispredict_count  output  CNT_W  mispredicts

Behaviour:
- Reset: out_valid=0, all result regs=0, counters=0, every BHT entry=2'b01 (weakly not-taken).
- Index: idx = pc[log2(BHT_ENTRIES)+ALIGN-1 : ALIGN], with ALIGN=2 (1 under macro).
- Accept: in_valid & in_ready.
  - Condition is computed combinationally and registered.
  - Result appears with out_valid=1 the next cycle (latency 1).
  - Result is held stable while out_valid & !out_ready.
- Condition logic:
  - valid = (cond & branch) | jump.
  - aligned = target_addr[ALIGN-1:0]==0.
  - branch_taken = valid & aligned.
  - misaligned_exception = valid & !aligned.
- Fall-through PC: fallthrough = in_pc+4, XLEN wrap.
- Mispredict (registered):
  - Set when !misaligned_exception & (branch_taken != pred_taken).
  - Also set when jump & !pred_taken.
  - Forced 0 on exception; the trap path owns the redirect.
- redirect_pc: target_addr if branch_taken, else fallthrough.
- BHT update on the output handshake (out_valid & out_ready & !flush), branch=1 and no exception only:
  - Counter at the resolved PC's index increments if cond is true, else decrements.
  - Counter saturates at 11 and 00.
  - Jumps never train.
- Same-cycle lookup and update at the same index: lookup_taken returns the pre-update value.
- Counters: increment on the same handshake, wrapping at 2^CNT_W.
  - branch_count counts branch=1.
  - mispredict_count counts mispredict=1.
- Flush:
  - Clears out_valid next edge and suppresses BHT/counter updates for the held result.
  - A request accepted in the flush cycle is discarded.
- branch & jump both 1: treated as jump.
- rst_n low mid-operation: immediate async return to reset state; BHT is reinitialised.

Optional Feature:
BRU_C_EXT_EN
- Defined:
  - ALIGN=1; only target_addr[0] checked.
  - fallthrough = in_pc + (is_compressed ? 2 : 4).
  - BHT indexed from pc[1].
- Undefined:
  - ALIGN=2; is_compressed ignored.
  - 4-byte alignment enforced.

Test Plan:
1. BEQ: src_a=src_b=0x5, pc=0x100, target=0x140, pred_taken=0 → next cycle out_valid=1, branch_taken=1, mispredict=1, redirect_pc=0x140, mispredict_count=1.
2. BLT vs BLTU: src_a=0xFFFFFFFF, src_b=1.
   - BLT → taken.
   - BLTU → not taken, redirect_pc=pc+4.
3. Misaligned JAL: target=0x102, jump=1 → misaligned_exception=1, branch_taken=0, mispredict=0, BHT unchanged.
   - With BRU_C_EXT_EN, same stimulus → branch_taken=1.
4. BHT saturation: pc=0x200 resolves taken 4 times → lookup_taken(0x200) becomes 1 after the first taken, counter=11.
   - One not-taken → still 1.
   - Two not-taken → 0.
5. Backpressure/flush: out_ready=0 for 3 cycles → result stable, in_ready=0, no BHT change.
   - Assert flush → out_valid=0 next cycle, branch_count unchanged.
6. Async reset mid-stall: rst_n low with out_valid=1 → out_valid=0 immediately, counters=0, lookup_taken=0 for all PCs.
